layer_mac_sequencer: RTL and testbench

- Sequences one shared multiply-accumulate datapath across all nodes of a dense layer.
- For each node it walks every input/weight pair, adds the node bias, applies ReLU, and hands the result downstream with a valid/ready handshake.
- Replaces per-node MAC instances. Sits between the input/weight/bias memories (1-cycle read latency) and the next-layer input buffer.

---
 rtl/layer_mac_sequencer.sv | 169 ++++++++++++++++
 tb/tb_layer_mac_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_mac_sequencer.sv
// Shares one Q16.16 multiply-accumulate datapath across every node of a dense layer.
// Optional ACC_SAT_EN: saturating product/accumulate and a sticky sat_flag output.
module layer_mac_sequencer #(
    parameter int N_INPUTS = 784,
    parameter int N_NODES  = 16,
    parameter int DATA_W   = 32,
    parameter int IN_AW    = $clog2(N_INPUTS),
    parameter int W_AW     = $clog2(N_INPUTS*N_NODES),
    parameter int NODE_W   = (N_NODES > 1) ? $clog2(N_NODES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [IN_AW-1:0]  in_addr,
    output logic [W_AW-1:0]   w_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] w_data,
    output logic [NODE_W-1:0] bias_addr,
    input  logic [DATA_W-1:0] bias_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [NODE_W-1:0] res_node
`ifdef ACC_SAT_EN
    ,
    output logic              sat_flag
`endif
);

    // IDLE wait start | LOAD clear acc, read idx 0 | MAC accumulate N_INPUTS products
    // BIAS add bias | ACT ReLU into res_* | WRITE handshake | FIN done pulse
    typedef enum logic [2:0] {IDLE, LOAD, MAC, BIAS, ACT, WRITE, FIN} state_t;

    localparam logic [IN_AW-1:0]  IDX_LAST  = IN_AW'(N_INPUTS - 1);
    localparam logic [NODE_W-1:0] NODE_LAST = NODE_W'(N_NODES - 1);

    state_t                     state, state_next;
    logic [IN_AW-1:0]           idx, mac_cnt;
    logic [NODE_W-1:0]          node;
    logic signed [DATA_W-1:0]   acc, acc_sum, addend, term;
    logic signed [2*DATA_W-1:0] in_ext, w_ext, prod;

    assign in_ext = {{DATA_W{in_data[DATA_W-1]}}, in_data};
    assign w_ext  = {{DATA_W{w_data[DATA_W-1]}}, w_data};
    assign prod   = in_ext * w_ext;

`ifdef ACC_SAT_EN
    localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    logic signed [2*DATA_W-1:0] prod_sh;
    logic                       term_ovf, sum_ovf;
    assign prod_sh = prod >>> 16;

    always_comb begin
        term     = prod_sh[DATA_W-1:0];
        term_ovf = 1'b0;
        if (prod_sh[2*DATA_W-1:DATA_W-1] != {(DATA_W+1){prod_sh[2*DATA_W-1]}}) begin
            term_ovf = 1'b1;
            term     = prod_sh[2*DATA_W-1] ? SAT_MIN : SAT_MAX;
        end
        addend  = (state == BIAS) ? bias_data : term;
        acc_sum = acc + addend;
        sum_ovf = 1'b0;
        if ((acc[DATA_W-1] == addend[DATA_W-1]) && (acc_sum[DATA_W-1] != acc[DATA_W-1])) begin
            sum_ovf = 1'b1;
            acc_sum = acc[DATA_W-1] ? SAT_MIN : SAT_MAX;
        end
    end
`else
    always_comb begin
        term    = DATA_W'(prod >>> 16);
        addend  = (state == BIAS) ? bias_data : term;
        acc_sum = acc + addend;
    end
`endif

    always_comb begin
        state_next = state;
        rd_en      = 1'b0;
        done       = 1'b0;
        res_valid  = 1'b0;
        case (state)
            IDLE:  if (start) state_next = LOAD;
            LOAD: begin
                rd_en      = 1'b1;
                state_next = MAC;
            end
            MAC: begin
                rd_en = (mac_cnt != '0);
                if (mac_cnt == '0) state_next = BIAS;
            end
            BIAS:  state_next = ACT;
            ACT:   state_next = WRITE;
            WRITE: begin
                res_valid = 1'b1;
                if (res_ready) state_next = (node == NODE_LAST) ? FIN : LOAD;
            end
            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            mac_cnt  <= '0;
            node     <= '0;
            acc      <= '0;
            res_data <= '0;
            res_node <= '0;
`ifdef ACC_SAT_EN
            sat_flag <= 1'b0;
`endif
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (start) begin
                    node <= '0;
                    idx  <= '0;
                end
                LOAD: begin
                    acc     <= '0;
                    idx     <= IN_AW'(1);
                    mac_cnt <= IDX_LAST;
`ifdef ACC_SAT_EN
                    sat_flag <= 1'b0;
`endif
                end
                MAC: begin
                    acc <= acc_sum;
                    if (mac_cnt != '0) mac_cnt <= mac_cnt - 1'b1;
                    // idx already holds the next address; it parks on the last one
                    if (rd_en && idx != IDX_LAST) idx <= idx + 1'b1;
`ifdef ACC_SAT_EN
                    sat_flag <= sat_flag | term_ovf | sum_ovf;
`endif
                end
                BIAS: begin
                    acc <= acc_sum;
`ifdef ACC_SAT_EN
                    sat_flag <= sat_flag | sum_ovf;
`endif
                end
                ACT: begin
                    res_data <= acc[DATA_W-1] ? '0 : acc;
                    res_node <= node;
                end
                WRITE: if (res_ready && node != NODE_LAST) begin
                    node <= node + 1'b1;
                    idx  <= '0;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign in_addr   = idx;
    assign bias_addr = node;
    assign w_addr    = W_AW'(node) * W_AW'(N_INPUTS) + W_AW'(idx);

endmodule

// File: tb/tb_layer_mac_sequencer.sv
// Self-checking bench for layer_mac_sequencer with a small layer and a 1-cycle memory model.
// Follows the ACC_SAT_EN build option of the design.
module tb_layer_mac_sequencer;
    localparam int N_IN = 4;
    localparam int N_ND = 2;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, rd_en, res_valid;
    logic        res_ready = 1'b1;
    logic [1:0]  in_addr;
    logic [2:0]  w_addr;
    logic [0:0]  bias_addr, res_node;
    logic [31:0] in_data = '0, w_data = '0, bias_data = '0, res_data;
`ifdef ACC_SAT_EN
    logic        sat_flag;
`endif

    logic [31:0] in_mem [N_IN];
    logic [31:0] w_mem  [N_IN*N_ND];
    logic [31:0] bias_mem [N_ND];

    int checks = 0;
    int errors = 0;

    layer_mac_sequencer #(.N_INPUTS(N_IN), .N_NODES(N_ND), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .rd_en(rd_en),
        .in_addr(in_addr), .w_addr(w_addr), .in_data(in_data), .w_data(w_data),
        .bias_addr(bias_addr), .bias_data(bias_data), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .res_node(res_node)
`ifdef ACC_SAT_EN
        , .sat_flag(sat_flag)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) begin
            in_data <= in_mem[in_addr];
            w_data  <= w_mem[w_addr];
        end
        bias_data <= bias_mem[bias_addr];
    end

    // Reference: plain 64-bit arithmetic, then wrap or clamp to 32 bits.
    bit model_sat;
    function automatic longint fix32(input longint v);
        logic [31:0] w;
`ifdef ACC_SAT_EN
        if (v > MAXV) begin model_sat = 1'b1; return MAXV; end
        if (v < MINV) begin model_sat = 1'b1; return MINV; end
        return v;
`else
        w = v[31:0];
        return longint'($signed(w));
`endif
    endfunction

    function automatic logic [31:0] model_node(input int n);
        longint acc, t;
        logic [31:0] r;
        acc = 0;
        model_sat = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            t = (longint'($signed(in_mem[i])) * longint'($signed(w_mem[n*N_IN+i]))) >>> 16;
            t = fix32(t);
            acc = fix32(acc + t);
        end
        acc = fix32(acc + longint'($signed(bias_mem[n])));
        r = (acc < 0) ? 32'h0 : acc[31:0];
        return r;
    endfunction

    logic [31:0] got_data [N_ND];
    int          got_node [N_ND];
    int          got_sat  [N_ND];
    int          accept_j [N_ND];
    int          n_acc, t_valid, t_done, w_n1i3, next_load_j;
    bit          stall_rd, stall_chg;

    task automatic run_pass(input int stall_node, input int stall_len, input int extra_start_j);
        int j;
        int left;
        logic [31:0] held;
        n_acc = 0; t_valid = -1; t_done = -1; w_n1i3 = -1; next_load_j = -1;
        stall_rd = 0; stall_chg = 0; held = '0;
        left = stall_len;
        @(negedge clk);
        start = 1'b1;
        res_ready = 1'b1;
        j = 0;
        while (j < 500 && t_done < 0) begin
            @(negedge clk);
            j++;
            start = (j == extra_start_j);
            if (rd_en && bias_addr == 1 && in_addr == 3) w_n1i3 = w_addr;
            if (rd_en && bias_addr == 1 && in_addr == 0 && next_load_j < 0) next_load_j = j;
            if (done) t_done = j;
            if (res_valid) begin
                if (t_valid < 0) t_valid = j;
                if (int'(res_node) == stall_node && left > 0) begin
                    if (left == stall_len) held = res_data;
                    else if (res_data !== held) stall_chg = 1;
                    if (rd_en) stall_rd = 1;
                    left--;
                    res_ready = 1'b0;
                end else begin
                    res_ready = 1'b1;
                    if (n_acc < N_ND) begin
                        got_data[n_acc] = res_data;
                        got_node[n_acc] = int'(res_node);
                        accept_j[n_acc] = j;
`ifdef ACC_SAT_EN
                        got_sat[n_acc] = int'(sat_flag);
`else
                        got_sat[n_acc] = 0;
`endif
                        n_acc++;
                    end
                end
            end else begin
                res_ready = 1'b1;
            end
        end
        start = 1'b0;
        res_ready = 1'b1;
    endtask

    task automatic fill_plan();
        for (int i = 0; i < N_IN; i++) begin
            in_mem[i] = 32'h0001_0000;
            w_mem[i] = 32'h0000_8000;
            w_mem[N_IN+i] = 32'hFFFF_0000;
        end
        bias_mem[0] = 32'h0001_0000;
        bias_mem[1] = 32'h0;
    endtask

    task automatic fill_random(input bit wide);
        for (int i = 0; i < N_IN; i++)
            in_mem[i] = wide ? $urandom : 32'(int'($urandom_range(0, 32'h7FFFF)) - 32'h40000);
        for (int i = 0; i < N_IN*N_ND; i++)
            w_mem[i] = wide ? $urandom : 32'(int'($urandom_range(0, 32'h7FFFF)) - 32'h40000);
        for (int n = 0; n < N_ND; n++)
            bias_mem[n] = 32'(int'($urandom_range(0, 32'h3FFFF)) - 32'h20000);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, rd_en, in_addr, w_addr, bias_addr, res_valid, res_data, res_node} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b done=%b rd=%b in=%0d w=%0d b=%0d v=%b d=%h n=%0d want all 0",
                     busy, done, rd_en, in_addr, w_addr, bias_addr, res_valid, res_data, res_node);
        end
`ifdef ACC_SAT_EN
        checks++;
        if (sat_flag !== 1'b0) begin errors++; $display("FAIL reset_sat got %b want 0", sat_flag); end
`endif
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        fill_plan();
        run_pass(-1, 0, -1);
        checks++; if (n_acc !== 2) begin errors++; $display("FAIL basic_count got %0d want 2", n_acc); end
        checks++; if (got_data[0] !== 32'h0003_0000) begin errors++; $display("FAIL basic_res0 got %h want 00030000", got_data[0]); end
        checks++; if (got_node[0] !== 0) begin errors++; $display("FAIL basic_node0 got %0d want 0", got_node[0]); end
        checks++; if (got_data[1] !== 32'h0) begin errors++; $display("FAIL basic_res1 got %h want 00000000", got_data[1]); end
        checks++; if (got_node[1] !== 1) begin errors++; $display("FAIL basic_node1 got %0d want 1", got_node[1]); end
        checks++; if (t_valid !== 8) begin errors++; $display("FAIL basic_first_valid got %0d want 8", t_valid); end
        checks++; if (t_done !== 17) begin errors++; $display("FAIL basic_done got %0d want 17", t_done); end
        checks++; if (w_n1i3 !== 7) begin errors++; $display("FAIL basic_waddr_n1i3 got %0d want 7", w_n1i3); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL basic_idle_after got busy=%b done=%b want 0 0", busy, done); end
    endtask

    task automatic test_backpressure();
        logic [31:0] e0, e1;
        fill_random(1'b0);
        e0 = model_node(0);
        e1 = model_node(1);
        run_pass(0, 5, -1);
        checks++; if (got_data[0] !== e0) begin errors++; $display("FAIL bp_res0 got %h want %h", got_data[0], e0); end
        checks++; if (got_data[1] !== e1) begin errors++; $display("FAIL bp_res1 got %h want %h", got_data[1], e1); end
        checks++; if (stall_chg !== 1'b0) begin errors++; $display("FAIL bp_data_stable got changed=%b want 0", stall_chg); end
        checks++; if (stall_rd !== 1'b0) begin errors++; $display("FAIL bp_no_reads got rd=%b want 0", stall_rd); end
        checks++; if (next_load_j !== accept_j[0] + 1) begin errors++; $display("FAIL bp_next_load got %0d want %0d", next_load_j, accept_j[0] + 1); end
        checks++; if (t_done !== 22) begin errors++; $display("FAIL bp_done got %0d want 22", t_done); end
    endtask

    task automatic test_mid_start();
        fill_plan();
        run_pass(-1, 0, 3);
        checks++; if (got_data[0] !== 32'h0003_0000) begin errors++; $display("FAIL midstart_res0 got %h want 00030000", got_data[0]); end
        checks++; if (t_done !== 17) begin errors++; $display("FAIL midstart_done got %0d want 17", t_done); end
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midstart_idle got busy=%b want 0", busy); end
    endtask

    task automatic test_midpass_reset();
        bit stray;
        logic [31:0] e0, e1;
        fill_random(1'b0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, rd_en, in_addr, w_addr, bias_addr, res_valid, res_data, res_node} !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs got busy=%b rd=%b in=%0d w=%0d v=%b d=%h want all 0",
                     busy, rd_en, in_addr, w_addr, res_valid, res_data);
        end
        rst = 1'b0;
        stray = 0;
        repeat (30) begin
            @(negedge clk);
            if (done || res_valid || busy) stray = 1;
        end
        checks++; if (stray !== 1'b0) begin errors++; $display("FAIL rst_mid_abandon got activity=%b want 0", stray); end
        e0 = model_node(0);
        e1 = model_node(1);
        run_pass(-1, 0, -1);
        checks++; if (got_data[0] !== e0 || got_data[1] !== e1) begin
            errors++; $display("FAIL rst_mid_rerun got %h %h want %h %h", got_data[0], got_data[1], e0, e1);
        end
        checks++; if (t_done !== 17) begin errors++; $display("FAIL rst_mid_done got %0d want 17", t_done); end
    endtask

    task automatic test_random();
        logic [31:0] exp_d [N_ND];
        int exp_s [N_ND];
        int sn, sl;
        for (int p = 0; p < 8; p++) begin
            fill_random(p[0]);
            for (int n = 0; n < N_ND; n++) begin
                exp_d[n] = model_node(n);
                exp_s[n] = int'(model_sat);
            end
            sl = $urandom_range(0, 6);
            sn = (sl == 0) ? -1 : int'($urandom_range(0, N_ND - 1));
            run_pass(sn, sl, -1);
            checks++; if (n_acc !== N_ND) begin errors++; $display("FAIL rand%0d_count got %0d want %0d", p, n_acc, N_ND); end
            for (int n = 0; n < N_ND; n++) begin
                checks++;
                if (got_data[n] !== exp_d[n] || got_node[n] !== n) begin
                    errors++; $display("FAIL rand%0d_node%0d got %h/%0d want %h/%0d", p, n, got_data[n], got_node[n], exp_d[n], n);
                end
`ifdef ACC_SAT_EN
                checks++;
                if (got_sat[n] !== exp_s[n]) begin errors++; $display("FAIL rand%0d_sat%0d got %0d want %0d", p, n, got_sat[n], exp_s[n]); end
`endif
            end
            checks++;
            if (t_done !== 1 + N_ND*(N_IN+4) + sl) begin
                errors++; $display("FAIL rand%0d_done got %0d want %0d", p, t_done, 1 + N_ND*(N_IN+4) + sl);
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] want;
        for (int i = 0; i < N_IN; i++) begin
            in_mem[i] = 32'h7FFF_0000;
            w_mem[i] = 32'h0002_0000;
            w_mem[N_IN+i] = 32'h0002_0000;
        end
        bias_mem[0] = 32'h0;
        bias_mem[1] = 32'h0;
`ifdef ACC_SAT_EN
        want = 32'h7FFF_FFFF;
`else
        want = 32'h0;
`endif
        run_pass(-1, 0, -1);
        checks++; if (got_data[0] !== want) begin errors++; $display("FAIL ovf_res0 got %h want %h", got_data[0], want); end
        checks++; if (got_data[1] !== want) begin errors++; $display("FAIL ovf_res1 got %h want %h", got_data[1], want); end
`ifdef ACC_SAT_EN
        checks++; if (got_sat[0] !== 1) begin errors++; $display("FAIL ovf_sat got %0d want 1", got_sat[0]); end
`endif
    endtask

    initial begin
        for (int i = 0; i < N_IN; i++) in_mem[i] = '0;
        for (int i = 0; i < N_IN*N_ND; i++) w_mem[i] = '0;
        for (int n = 0; n < N_ND; n++) bias_mem[n] = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_mid_start();
        test_midpass_reset();
        test_random();
        test_overflow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
